clk_period_monitor: RTL and testbench

Measures the period of a slow square-wave clock, such as the divided drive-rate clock, in cycles of the fast system clock. Reports each measured period and flags periods outside an allowed window. Declares lock after a run of good periods. Detects loss of the monitored clock by timeout. Sits beside the rate dividers as the checking end of the divided-clock interface, feeding the VFD fault and status logic.

---
 rtl/clk_period_monitor.sv | 129 ++++++++++++
 tb/tb_clk_period_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures the period of a slow square wave in clk_in
// cycles, flags periods outside [MIN_PERIOD, MAX_PERIOD], declares lock after
// LOCK_CNT good periods in a row and reports loss of the signal by timeout.
module clk_period_monitor #(
    parameter int CNT_W      = 12,
    parameter int MIN_PERIOD = 780,
    parameter int MAX_PERIOD = 788,
    parameter int TIMEOUT    = 1600,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             in_range,
    output logic             locked,
    output logic             timeout
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] TOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_CNT);
    localparam logic [GW-1:0]    GONE_C = GW'(1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state, state_d;
    logic             s1, s2, s3;
    logic             sig_rise;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [GW-1:0]    good_cnt, good_d;
    logic [CNT_W-1:0] period_d;
    logic             valid_d, range_d, locked_d, timeout_d;
    logic             win;

    // two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_rise = s2 & ~s3;
    assign win      = (cnt >= MIN_C) && (cnt <= MAX_C);

    // next-state and next-output logic; an edge takes priority over timeout
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        good_d    = good_cnt;
        period_d  = period_out;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        range_d   = in_range;
        locked_d  = locked;
        case (state)
            IDLE: begin
                // first edge only arms the measurement
                cnt_d = '0;
                if (sig_rise) begin
                    cnt_d   = ONE_C;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (sig_rise) begin
                    period_d = cnt;
                    valid_d  = 1'b1;
                    range_d  = win;
                    cnt_d    = ONE_C;
                    if (win) begin
                        if (good_cnt < LOCK_C)
                            good_d = good_cnt + GONE_C;
                        if (good_d == LOCK_C)
                            locked_d = 1'b1;
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end else if (cnt == TOUT_C) begin
                    // period_out deliberately keeps the last good measurement
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    range_d   = 1'b0;
                    good_d    = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + ONE_C;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            good_cnt     <= good_d;
            period_out   <= period_d;
            period_valid <= valid_d;
            in_range     <= range_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor: directed bench for clk_period_monitor with
// hand-computed periods, window flags, lock progression and timeout timing.
module tb_clk_period_monitor;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        sig_in = 1'b0;
    logic [11:0] period_out;
    logic        period_valid, in_range, locked, timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int both_seen = 0;
    int rst_bad   = 0;

    int pv_p[$], pv_ir[$], pv_lk[$], pv_cyc[$], to_cyc[$], rise_cyc[$];
    int ep[$], eir[$], elk[$];

    clk_period_monitor dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .in_range     (in_range),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // record pulses on the falling edge, away from the active edge
    always @(negedge clk_in) begin
        if (period_valid) begin
            pv_p.push_back(int'(period_out));
            pv_ir.push_back(int'(in_range));
            pv_lk.push_back(int'(locked));
            pv_cyc.push_back(cyc);
        end
        if (timeout) to_cyc.push_back(cyc);
        if (period_valid && timeout) both_seen = 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // one rising edge, then hold for the rest of a p-cycle period
    task automatic rise(input int p);
        rise_cyc.push_back(cyc);
        sig_in = 1'b1;
        repeat (p / 2) @(posedge clk_in);
        #1 sig_in = 1'b0;
        repeat (p - p / 2) @(posedge clk_in);
        #1;
    endtask

    task automatic clr();
        pv_p.delete(); pv_ir.delete(); pv_lk.delete(); pv_cyc.delete();
        to_cyc.delete(); rise_cyc.delete();
        ep.delete(); eir.delete(); elk.delete();
    endtask

    task automatic exp_add(input int p, input int ir, input int lk);
        ep.push_back(p); eir.push_back(ir); elk.push_back(lk);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_npulse"}, pv_p.size(), ep.size());
        for (int i = 0; i < ep.size(); i++) begin
            if (i < pv_p.size()) begin
                chk($sformatf("%s_period%0d", tag, i), pv_p[i], ep[i]);
                chk($sformatf("%s_range%0d", tag, i), pv_ir[i], eir[i]);
                chk($sformatf("%s_lock%0d", tag, i), pv_lk[i], elk[i]);
            end
        end
    endtask

    initial begin
        // reset held while sig_in toggles: outputs must stay 0
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1 sig_in = i[1];
            @(negedge clk_in);
            rst_bad = rst_bad | int'(period_valid | in_range | locked | timeout)
                      | int'(period_out != 0);
        end
        chk("reset_outputs", rst_bad, 0);
        @(posedge clk_in); #1 sig_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        clr();

        // nominal 784-cycle periods, six edges -> five reports, lock on 4th
        for (int i = 0; i < 6; i++) rise(784);
        exp_add(784, 1, 0); exp_add(784, 1, 0); exp_add(784, 1, 0);
        exp_add(784, 1, 1); exp_add(784, 1, 1);
        chk_seq("nominal");
        if (pv_cyc.size() >= 2 && rise_cyc.size() >= 2) begin
            chk("latency", pv_cyc[0] - rise_cyc[1], 3);
            chk("spacing", pv_cyc[1] - pv_cyc[0], 784);
        end else begin
            chk("latency_missing", pv_cyc.size(), 5);
        end

        // loss: hold low well past the timeout
        repeat (1000) @(posedge clk_in);
        #1;
        chk("loss_npulse", to_cyc.size(), 1);
        if (to_cyc.size() >= 1 && pv_cyc.size() >= 5)
            chk("loss_delay", to_cyc[0] - pv_cyc[4], 1600);
        @(negedge clk_in);
        chk("loss_locked", int'(locked), 0);
        chk("loss_range", int'(in_range), 0);
        chk("loss_period_held", int'(period_out), 784);
        @(posedge clk_in); #1;
        clr();
        rise(784);
        rise(784);
        exp_add(784, 1, 0);
        chk_seq("relearn");
        clr();

        // window boundaries; lock count restarts after every bad period
        rise(779); rise(780); rise(788); rise(789);
        for (int i = 0; i < 5; i++) rise(784);
        exp_add(784, 1, 0); exp_add(779, 0, 0); exp_add(780, 1, 0);
        exp_add(788, 1, 0); exp_add(789, 0, 0); exp_add(784, 1, 0);
        exp_add(784, 1, 0); exp_add(784, 1, 0); exp_add(784, 1, 1);
        chk_seq("window");
        clr();

        // edge arriving exactly at the timeout count is reported, no timeout
        rise(1600);
        for (int i = 0; i < 5; i++) rise(784);
        exp_add(784, 1, 1); exp_add(1600, 0, 0); exp_add(784, 1, 0);
        exp_add(784, 1, 0); exp_add(784, 1, 0); exp_add(784, 1, 1);
        chk_seq("tie");
        chk("tie_no_timeout", to_cyc.size(), 0);

        // reset in the middle of a locked period clears at once
        repeat (100) @(posedge clk_in);
        #1;
        chk("pre_reset_locked", int'(locked), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_period", int'(period_out), 0);
        chk("async_rst_range", int'(in_range), 0);
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        clr();
        for (int i = 0; i < 5; i++) rise(784);
        exp_add(784, 1, 0); exp_add(784, 1, 0); exp_add(784, 1, 0);
        exp_add(784, 1, 1);
        chk_seq("relock");

        chk("pulse_overlap", both_seen, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
